// File: rtl/debug_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_pkg : state encodings and command bytes shared by the debug loader
// Revision  : 1.0
// ---------------------------------------------------------------------------
package debug_pkg;

  localparam int STATE_W = 3;
  localparam int BYTE_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h4C;
  localparam logic [BYTE_W-1:0] CMD_CONT = 8'h43;
  localparam logic [BYTE_W-1:0] CMD_STEP = 8'h53;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/debug_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_loader_if : UART byte input, halt level and program-memory write port
// Revision        : 1.0
// ---------------------------------------------------------------------------
interface debug_loader_if
  import debug_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic [BYTE_W-1:0]     i_rx_data;
  logic                  i_rx_done;
  logic                  i_halt;
  logic                  o_program_memory_write;
  logic [DATA_WIDTH-1:0] o_instruction_write;
  logic [ADDR_WIDTH-1:0] o_address_write;
  logic                  o_step;
  logic [STATE_W-1:0]    o_state;
  logic [ADDR_WIDTH:0]   o_word_count;

  modport master (
    input  i_rx_data, i_rx_done, i_halt,
    output o_program_memory_write, o_instruction_write, o_address_write,
    output o_step, o_state, o_word_count
  );

  modport slave (
    output i_rx_data, i_rx_done, i_halt,
    input  o_program_memory_write, o_instruction_write, o_address_write,
    input  o_step, o_state, o_word_count
  );

endinterface
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_assembler : packs big-endian bytes into words, one-cycle valid pulse
// Revision       : 1.0
// ---------------------------------------------------------------------------
module word_assembler
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int BYTES = DATA_WIDTH / BYTE_W;
  localparam int CNT_W = $clog2(BYTES);
  localparam int SHR_W = DATA_WIDTH - BYTE_W;

  logic [CNT_W-1:0]      cnt_q;
  logic [SHR_W-1:0]      shift_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (byte_valid_i) begin
        shift_q <= {shift_q[SHR_W-BYTE_W-1:0], byte_i};
        if (cnt_q == CNT_W'(BYTES - 1)) begin
          // Last byte bypasses the shift register so the word is ready next cycle
          cnt_q   <= '0;
          word_q  <= {shift_q, byte_i};
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule
`default_nettype wire

// File: rtl/debug_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_loader : loads program words from UART bytes, then runs/steps fetch
// Revision     : 1.0
// ---------------------------------------------------------------------------
module debug_loader
  import debug_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  debug_loader_if.master bus
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  step_q, step_d;
  logic                  clear_d;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_d),
    .byte_valid_i (bus.i_rx_done && (state_q == ST_LOAD)),
    .byte_i       (bus.i_rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    step_d  = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_rx_done && (bus.i_rx_data == CMD_LOAD)) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          count_d = '0;
          clear_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          count_d = count_q + 1'b1;
          // Saturate at the top address so a full memory never wraps onto word 0
          if (addr_q != '1) begin
            addr_d = addr_q + 1'b1;
          end
          if ((word == HALT_WORD) || (addr_q == '1)) begin
            state_d = ST_READY;
            clear_d = 1'b1;
          end
        end
      end
      ST_READY: begin
        if (bus.i_halt) begin
          state_d = ST_DONE;
        end else if (bus.i_rx_done) begin
          if (bus.i_rx_data == CMD_STEP) begin
            step_d = 1'b1;
          end else if (bus.i_rx_data == CMD_CONT) begin
            state_d = ST_RUN;
            step_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.i_halt) begin
          state_d = ST_DONE;
        end else begin
          step_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_program_memory_write = word_valid;
  assign bus.o_instruction_write    = word;
  assign bus.o_address_write        = addr_q;
  assign bus.o_step                 = step_q;
  assign bus.o_state                = state_q;
  assign bus.o_word_count           = count_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_debug_loader : scoreboard bench for debug_loader (writes, step, states)
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_debug_loader;
  import debug_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  debug_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  debug_loader #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [39:0] exp_q[$];
  int unsigned exp_addr = 0;
  int          wr0_cnt  = 0;
  int          step_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_rx_done = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    exp_q.push_back({8'(exp_addr), w});
    exp_addr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_halt    = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    exp_addr = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, bus.o_state, ST_IDLE);
    chk({tag, "_step"}, bus.o_step, 1'b0);
    chk({tag, "_wr"}, bus.o_program_memory_write, 1'b0);
    chk({tag, "_instr"}, bus.o_instruction_write, 32'h0);
    chk({tag, "_addr"}, bus.o_address_write, 8'h0);
    chk({tag, "_wcount"}, bus.o_word_count, 9'h0);
  endtask

  // Scoreboard: every write pulse must match the oldest pending expectation
  always @(negedge clk) begin
    logic [39:0] e;
    if (bus.o_step) step_cnt++;
    if (bus.o_program_memory_write) begin
      if (bus.o_address_write == 8'h00) wr0_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_wr", bus.o_program_memory_write, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.o_address_write, e[39:32]);
        chk("wr_data", bus.o_instruction_write, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_halt    = 1'b0;
    do_reset();
    check_reset_values("rst");

    // Single word, load stays open
    send_byte(CMD_LOAD);
    send_word(32'h2008_0005);
    quiet(3);
    chk("t1_state", bus.o_state, ST_LOAD);
    chk("t1_wcount", bus.o_word_count, 9'd1);
    chk("t1_pending", exp_q.size(), 0);

    // Two words (one full of command codes) then HALT closes the load
    do_reset();
    send_byte(CMD_LOAD);
    send_word(32'h4C53_434C);
    send_word(32'hDEAD_BEEF);
    send_word(HALT_WORD);
    quiet(3);
    chk("t2_state", bus.o_state, ST_READY);
    chk("t2_wcount", bus.o_word_count, 9'd3);
    chk("t2_pending", exp_q.size(), 0);

    // Three single steps
    step_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(CMD_STEP);
      quiet(1);
      chk("t3_step_hi", bus.o_step, 1'b1);
      quiet(1);
      chk("t3_step_lo", bus.o_step, 1'b0);
      quiet(1);
    end
    chk("t3_step_cnt", step_cnt, 3);
    chk("t3_state", bus.o_state, ST_READY);

    // Continuous run, bytes ignored, halt stops it
    send_byte(CMD_CONT);
    quiet(1);
    chk("t4_step_first", bus.o_step, 1'b1);
    send_byte(CMD_LOAD);
    quiet(3);
    chk("t4_step_held", bus.o_step, 1'b1);
    chk("t4_state_run", bus.o_state, ST_RUN);
    @(negedge clk);
    bus.i_halt = 1'b1;
    @(negedge clk);
    chk("t4_step_off", bus.o_step, 1'b0);
    chk("t4_state_done", bus.o_state, ST_DONE);
    bus.i_halt = 1'b0;
    send_byte(CMD_STEP);
    quiet(1);
    chk("t4_done_step", bus.o_step, 1'b0);
    quiet(1);
    chk("t4_done_state", bus.o_state, ST_DONE);

    // Halt wins over a simultaneous step in READY
    exp_addr = 0;
    send_byte(CMD_LOAD);
    send_word(HALT_WORD);
    quiet(3);
    chk("prio_ready", bus.o_state, ST_READY);
    send_byte(CMD_STEP);
    bus.i_halt = 1'b1;
    quiet(1);
    chk("prio_step", bus.o_step, 1'b0);
    chk("prio_state", bus.o_state, ST_DONE);
    bus.i_halt = 1'b0;

    // Fill all 256 words: last at 255, no wrap to 0
    exp_addr = 0;
    send_byte(CMD_LOAD);
    quiet(1);
    wr0_cnt = 0;
    for (int i = 0; i < 256; i++) send_word({8'hA5, 8'(i), 16'h1234});
    quiet(4);
    chk("t5_state", bus.o_state, ST_READY);
    chk("t5_wcount", bus.o_word_count, 9'd256);
    chk("t5_addr", bus.o_address_write, 8'hFF);
    chk("t5_wr0", wr0_cnt, 1);
    chk("t5_pending", exp_q.size(), 0);

    // Reset mid-word discards the partial bytes
    do_reset();
    send_byte(CMD_LOAD);
    send_byte(8'h12);
    send_byte(8'h34);
    do_reset();
    check_reset_values("t6");
    quiet(3);
    chk("t6_state_idle", bus.o_state, ST_IDLE);
    send_byte(CMD_LOAD);
    send_word(32'hCAFE_F00D);
    quiet(3);
    chk("t6_reload_wcount", bus.o_word_count, 9'd1);

    // Reset while running drops step
    do_reset();
    send_byte(CMD_LOAD);
    send_word(HALT_WORD);
    quiet(2);
    send_byte(CMD_CONT);
    quiet(2);
    chk("rrun_step_hi", bus.o_step, 1'b1);
    do_reset();
    chk("rrun_step_lo", bus.o_step, 1'b0);
    chk("rrun_state", bus.o_state, ST_IDLE);

    quiet(2);
    chk("final_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
